// File: rtl/ft600_pkg.sv
// Shared types for the FT600 245-sync-FIFO bus scheduler: FSM states, grant side
// and the alternating-priority arbitration rule used when both directions request.
package ft600_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_OE,
        ST_RD_DATA,
        ST_RD_END,
        ST_WR_DATA,
        ST_WR_END
    } ft600_state_t;

    typedef enum logic {
        GRANT_RD,
        GRANT_WR
    } ft600_grant_t;

    localparam logic [1:0] BE_ALL = '1;

    // On a tie the side that did not win last time gets the bus.
    function automatic ft600_grant_t ft600_arbitrate(
        input logic         rd_req,
        input logic         wr_req,
        input ft600_grant_t last
    );
        if (rd_req && wr_req) begin
            return (last == GRANT_WR) ? GRANT_RD : GRANT_WR;
        end else if (rd_req) begin
            return GRANT_RD;
        end else begin
            return GRANT_WR;
        end
    endfunction

endpackage

// File: rtl/ft600_bus_scheduler.sv
// FT600 245-sync-FIFO bus owner: sequences bounded read/write bursts on the shared bus.
// Latency: rx word 1 edge after capture; tx accepted combinationally; backpressure via rx_afull/txe_n.
// Backpressure: rx_afull ends a read burst (one extra word in flight); txe_n high stalls/ends writes.
module ft600_bus_scheduler
    import ft600_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int BE_W      = 2,
    parameter int MAX_BURST = 256
) (
    input  logic              ftdi_clk,
    input  logic              rst,
    input  logic              ftdi_rxf_n,
    input  logic              ftdi_txe_n,
    output logic              ftdi_oe_n,
    output logic              ftdi_rd_n,
    output logic              ftdi_wr_n,
    input  logic [DATA_W-1:0] ftdi_data_i,
    input  logic [BE_W-1:0]   ftdi_be_i,
    output logic [DATA_W-1:0] ftdi_data_o,
    output logic [BE_W-1:0]   ftdi_be_o,
    output logic              ftdi_bus_oe,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic [BE_W-1:0]   rx_be,
    input  logic              rx_afull,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [BE_W-1:0]   tx_be,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_BURST - 1);

    ft600_state_t     state;
    ft600_grant_t     last_grant;
    ft600_grant_t     grant;
    logic [CNT_W-1:0] burst_cnt;
    logic             rd_req;
    logic             wr_req;
    logic             rd_cap;
    logic             wr_xfer;

    assign rd_req  = !ftdi_rxf_n && !rx_afull;
    assign wr_req  = !ftdi_txe_n && tx_valid;
    assign grant   = ft600_arbitrate(rd_req, wr_req, last_grant);
    assign rd_cap  = (state == ST_RD_DATA) && !ftdi_rd_n && !ftdi_rxf_n;
    assign wr_xfer = (state == ST_WR_DATA) && tx_valid && !ftdi_txe_n;

    // Write side is combinational so a txe_n rise stops the strobe in the same cycle.
    assign ftdi_bus_oe = (state == ST_WR_DATA);
    assign tx_ready    = (state == ST_WR_DATA) && !ftdi_txe_n;
    assign ftdi_wr_n   = !wr_xfer;
    assign ftdi_data_o = tx_data;
    assign ftdi_be_o   = tx_be;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge ftdi_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_WR;
            burst_cnt  <= '0;
            ftdi_oe_n  <= 1'b1;
            ftdi_rd_n  <= 1'b1;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            rx_be      <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_req || wr_req) begin
                        last_grant <= grant;
                        if (grant == GRANT_RD) begin
                            state     <= ST_RD_OE;
                            ftdi_oe_n <= 1'b0;
                        end else begin
                            state <= ST_WR_DATA;
                        end
                    end
                end
                ST_RD_OE: begin
                    // One turnaround cycle with oe_n low before the first read strobe.
                    state     <= ST_RD_DATA;
                    ftdi_rd_n <= 1'b0;
                end
                ST_RD_DATA: begin
                    if (rd_cap) begin
                        rx_valid  <= 1'b1;
                        rx_data   <= ftdi_data_i;
                        rx_be     <= ftdi_be_i;
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                    if (ftdi_rxf_n || rx_afull || (rd_cap && burst_cnt == LAST_CNT)) begin
                        state     <= ST_RD_END;
                        ftdi_rd_n <= 1'b1;
                        ftdi_oe_n <= 1'b1;
                    end
                end
                ST_RD_END: begin
                    state     <= ST_IDLE;
                    burst_cnt <= '0;
                end
                ST_WR_DATA: begin
                    if (wr_xfer) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                    if (!tx_valid || ftdi_txe_n || (wr_xfer && burst_cnt == LAST_CNT)) begin
                        state <= ST_WR_END;
                    end
                end
                ST_WR_END: begin
                    state     <= ST_IDLE;
                    burst_cnt <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
